// File: rtl/di_na_bridge_pkt_arbiter_pkg.sv
// Shared FSM state encoding and counter sizing for the DI/NA bridge packet arbiter.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package di_na_bridge_pkt_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_FORWARD = 2'd1,
        ST_DRAIN   = 2'd2
    } state_t;

    // Bits needed to count 0..max_words accepted flits.
    function automatic int cnt_width(input int max_words);
        return (max_words < 1) ? 1 : $clog2(max_words + 1);
    endfunction

endpackage

// File: rtl/di_na_bridge_rr_arb.sv
// Round-robin requester select: first set request at or after ptr, wrapping.
// Latency: purely combinational.
// Backpressure: none; caller decides when to sample the grant.
module di_na_bridge_rr_arb
    import di_na_bridge_pkt_arbiter_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt_onehot,
    output logic [IW-1:0] gnt_idx,
    output logic          gnt_vld
);

    int k;

    // Scan from the priority pointer and take the first active request.
    always_comb begin
        gnt_onehot = '0;
        gnt_idx    = '0;
        gnt_vld    = 1'b0;
        k          = 0;
        for (int i = 0; i < N; i++) begin
            k = (int'(ptr) + i) % N;
            if (!gnt_vld && req[k]) begin
                gnt_vld       = 1'b1;
                gnt_onehot[k] = 1'b1;
                gnt_idx       = IW'(k);
            end
        end
    end

endmodule

// File: rtl/di_na_bridge_pkt_arbiter.sv
// Round-robin packet arbiter muxing NUM_REQ flit streams to one packetizer stream.
// Latency: 1 cycle arbitration in IDLE, then flits pass combinationally from owner.
// Backpressure: owner ready follows out_flit_ready; overlong tails drained with ready=1.
module di_na_bridge_pkt_arbiter
    import di_na_bridge_pkt_arbiter_pkg::*;
#(
    parameter int NUM_REQ            = 4,
    parameter int MAX_DATA_NUM_WORDS = 12,
    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
    localparam int CW = cnt_width(MAX_DATA_NUM_WORDS)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0][15:0] in_flit_data,
    input  logic [NUM_REQ-1:0]       in_flit_valid,
    input  logic [NUM_REQ-1:0]       in_flit_last,
    output logic [NUM_REQ-1:0]       in_flit_ready,
    input  logic [NUM_REQ-1:0][15:0] in_dest,
    output logic [15:0]              out_flit_data,
    output logic                     out_flit_valid,
    output logic                     out_flit_last,
    input  logic                     out_flit_ready,
    output logic [15:0]              out_dest,
    output logic [IW-1:0]            grant_idx,
    output logic                     overlong_err
);

    localparam logic [CW-1:0] CNT_MAX_M1 = CW'(MAX_DATA_NUM_WORDS - 1);
    localparam logic [IW-1:0] LAST_REQ   = IW'(NUM_REQ - 1);

    state_t               state;
    logic [NUM_REQ-1:0]   grant_oh;
    logic [IW-1:0]        rr_ptr;
    logic [CW-1:0]        cnt;

    logic [NUM_REQ-1:0]   arb_oh;
    logic [IW-1:0]        arb_idx;
    logic                 arb_vld;

    logic                 cur_vld;
    logic                 cur_last;
    logic                 at_max;

    di_na_bridge_rr_arb #(
        .N  (NUM_REQ),
        .IW (IW)
    ) u_rr_arb (
        .req        (in_flit_valid),
        .ptr        (rr_ptr),
        .gnt_onehot (arb_oh),
        .gnt_idx    (arb_idx),
        .gnt_vld    (arb_vld)
    );

    assign cur_vld  = in_flit_valid[grant_idx];
    assign cur_last = in_flit_last[grant_idx];
    // This flit is the MAX-th one of the packet.
    assign at_max   = (cnt == CNT_MAX_M1);

    // Output mux and per-requester ready; everything is held off during reset.
    always_comb begin
        out_flit_data  = in_flit_data[grant_idx];
        out_flit_valid = 1'b0;
        out_flit_last  = 1'b0;
        in_flit_ready  = '0;
        overlong_err   = 1'b0;
        if (!rst) begin
            case (state)
                ST_FORWARD: begin
                    out_flit_valid = cur_vld;
                    out_flit_last  = cur_vld & (cur_last | at_max);
                    in_flit_ready  = grant_oh & {NUM_REQ{out_flit_ready}};
                    overlong_err   = cur_vld & out_flit_ready & at_max & ~cur_last;
                end
                ST_DRAIN: begin
                    in_flit_ready = grant_oh;
                end
                default: ;
            endcase
        end
    end

    // Packet FSM: grant in IDLE, count forwarded flits, drain truncated tails.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            grant_idx <= '0;
            grant_oh  <= '0;
            rr_ptr    <= '0;
            out_dest  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (arb_vld) begin
                        grant_idx <= arb_idx;
                        grant_oh  <= arb_oh;
                        out_dest  <= in_dest[arb_idx];
                        cnt       <= '0;
                        rr_ptr    <= (arb_idx == LAST_REQ) ? '0 : arb_idx + IW'(1);
                        state     <= ST_FORWARD;
                    end
                end
                ST_FORWARD: begin
                    if (cur_vld && out_flit_ready) begin
                        cnt <= cnt + CW'(1);
                        if (cur_last)
                            state <= ST_IDLE;
                        else if (at_max)
                            state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (cur_vld && cur_last)
                        state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/di_na_bridge_pkt_arbiter.md
DI_NA_BRIDGE_PKT_ARBITER -- requirements
Module: di_na_bridge_pkt_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, meaning number of 16-bit packet requesters (2..8).
REQ-002 SHALL have parameter MAX_DATA_NUM_WORDS, default 12, meaning maximum payload flits per packet forwarded to the packetizer.
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port in_flit_data  input  NUM_REQ x 16  per-requester flit payload.
REQ-006 SHALL have ports in_flit_valid / in_flit_last  input  NUM_REQ each  per-requester valid and end-of-packet.
REQ-007 SHALL have port in_flit_ready  output  NUM_REQ  per-requester ready.
REQ-008 SHALL have port in_dest  input  NUM_REQ x 16  per-requester DI destination address.
REQ-009 SHALL have ports out_flit_data (16), out_flit_valid (1), out_flit_last (1)  output  stream to packetizer.
REQ-010 SHALL have port out_flit_ready  input  1  packetizer ready.
REQ-011 SHALL have port out_dest  output  16  DI destination for current packet.
REQ-012 SHALL have port grant_idx  output  clog2(NUM_REQ)  index of current owner.
REQ-013 SHALL have port overlong_err  output  1  one-cycle pulse on packet truncation.

Function
REQ-014 SHALL implement FSM states IDLE, FORWARD, DRAIN.
REQ-015 IDLE: out_flit_valid=0, all in_flit_ready=0; if any in_flit_valid, select round-robin starting at (last grant+1) mod NUM_REQ, register grant_idx, latch in_dest[grant] into out_dest, go FORWARD next cycle.
REQ-016 Arbitration latency SHALL be exactly one cycle from valid in IDLE to first out_flit_valid.
REQ-017 FORWARD: out_flit_data/valid/last SHALL mux granted requester combinationally; in_flit_ready[grant]=out_flit_ready; other readies 0.
REQ-018 Flit counter (width clog2(MAX_DATA_NUM_WORDS+1)) SHALL reset to 0 on grant and increment per accepted flit (valid&ready).
REQ-019 Accepted flit with in_flit_last=1 SHALL return to IDLE next cycle.
REQ-020 MAX_DATA_NUM_WORDS-th accepted flit without in_flit_last SHALL drive out_flit_last=1 (forced), pulse overlong_err same cycle, go DRAIN.
REQ-021 Flit that is both last and MAX-th SHALL go IDLE without error.
REQ-022 DRAIN: out_flit_valid=0, in_flit_ready[grant]=1; discard flits until accepted flit with last, then IDLE.
REQ-023 Priority pointer SHALL update only at grant; a single active requester SHALL be regranted back-to-back with one idle cycle between packets.
REQ-024 out_dest and grant_idx SHALL stay stable from grant until return to IDLE regardless of in_dest changes.
REQ-025 Requesters deasserting valid mid-packet SHALL stall the output (out_flit_valid=0) without losing ownership.

Reset
REQ-026 On rst: state=IDLE, counter=0, grant_idx=0, round-robin pointer so requester 0 has highest priority, out_dest=0, overlong_err=0, all valid/ready outputs 0.
REQ-027 rst asserted mid-packet SHALL abort the packet; no flit accepted in the rst cycle.

Structure
REQ-028 Shared package SHALL hold the FSM state enum and a function computing counter width; no other typedefs.
REQ-029 Round-robin selection SHALL be one sub-module, di_na_bridge_rr_arb (request vector, pointer in, one-hot/index grant out, combinational).
REQ-030 Block SHALL contain no buffering; full-packet buffering remains in the downstream packetizer.

Verification
REQ-031 Req 1 only, 3-flit packet, ready=1 -> first out valid 1 cycle after request, 3 flits out, last on 3rd, out_dest=in_dest[1].
REQ-032 Req 0 and 2 valid simultaneously after reset -> req 0 packet first, then req 2, one IDLE cycle between.
REQ-033 All 4 requesters continuously valid -> grant order 0,1,2,3,0.
REQ-034 Req 3 sends 15 flits, MAX=12 -> 12 forwarded, last forced on 12th, overlong_err one cycle, 3 flits drained, out_flit_valid=0 during drain.
REQ-035 out_flit_ready toggled 1/0 every cycle during 5-flit packet -> all 5 flits delivered in order, none duplicated.
REQ-036 rst asserted after 2nd flit of a packet -> next cycle IDLE, outputs 0, next grant to requester 0 if valid.
